// File: rtl/wbu_commit_arbiter.sv
// Writeback commit arbiter: pops way0/way1 WBU buffer entries in pID order and drives
// two registered integer register-file write ports (port 0 older, port 1 younger).
module wbu_commit_arbiter #(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned ADDR_WIDTH  = 5,
  parameter int unsigned PID_WIDTH   = 2,
  parameter int unsigned STALL_LIMIT = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  way0_valid_i,
  input  logic                  way0_wen_i,
  input  logic [ADDR_WIDTH-1:0] way0_rd_addr_i,
  input  logic [DATA_WIDTH-1:0] way0_rd_data_i,
  input  logic [PID_WIDTH-1:0]  way0_pid_i,
  output logic                  way0_ready_o,
  input  logic                  way1_valid_i,
  input  logic                  way1_wen_i,
  input  logic [ADDR_WIDTH-1:0] way1_rd_addr_i,
  input  logic [DATA_WIDTH-1:0] way1_rd_data_i,
  input  logic [PID_WIDTH-1:0]  way1_pid_i,
  output logic                  way1_ready_o,
  input  logic                  commit_en_i,
  input  logic                  flush_i,
  input  logic [PID_WIDTH-1:0]  flush_pid_i,
  output logic                  rf_wen0_o,
  output logic [ADDR_WIDTH-1:0] rf_waddr0_o,
  output logic [DATA_WIDTH-1:0] rf_wdata0_o,
  output logic                  rf_wen1_o,
  output logic [ADDR_WIDTH-1:0] rf_waddr1_o,
  output logic [DATA_WIDTH-1:0] rf_wdata1_o,
  output logic [1:0]            retired_o,
  output logic [PID_WIDTH-1:0]  exp_pid_o,
  output logic                  pid_conflict_o,
  output logic                  deadlock_o
);

  localparam int unsigned CNT_WIDTH = $clog2(STALL_LIMIT + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(STALL_LIMIT);

  logic [PID_WIDTH-1:0]  exp_pid;
  logic [PID_WIDTH-1:0]  exp_pid_p1;
  logic [CNT_WIDTH-1:0]  stall_cnt;
  logic [CNT_WIDTH-1:0]  stall_nxt;
  logic                  active;
  logic                  m0, m1, n0, n1;
  logic                  c0, c1, swap, conflict;
  logic [1:0]            n_commit;
  logic                  p0_commit, p1_commit;
  logic                  p0_wen, p1_wen;
  logic [ADDR_WIDTH-1:0] p0_addr, p1_addr;
  logic [DATA_WIDTH-1:0] p0_data, p1_data;
  logic                  p0_from_way1;
  logic                  waw;

  assign active     = commit_en_i & ~flush_i;
  assign exp_pid_p1 = exp_pid + PID_WIDTH'(1);
  assign m0 = way0_valid_i & (way0_pid_i == exp_pid);
  assign m1 = way1_valid_i & (way1_pid_i == exp_pid);
  assign n0 = way0_valid_i & (way0_pid_i == exp_pid_p1);
  assign n1 = way1_valid_i & (way1_pid_i == exp_pid_p1);

  // Commit selection; swap means way1 is the older entry and goes to port 0
  always_comb begin
    c0       = 1'b0;
    c1       = 1'b0;
    swap     = 1'b0;
    conflict = 1'b0;
    if (active) begin
      if (m0 && n1) begin
        c0 = 1'b1;
        c1 = 1'b1;
      end else if (m1 && n0) begin
        c0   = 1'b1;
        c1   = 1'b1;
        swap = 1'b1;
      end else if (m0 && m1) begin
        c0       = 1'b1;
        conflict = 1'b1;
      end else if (m0) begin
        c0 = 1'b1;
      end else if (m1) begin
        c1 = 1'b1;
      end
    end
  end

  assign way0_ready_o = c0;
  assign way1_ready_o = c1;
  assign n_commit     = {1'b0, c0} + {1'b0, c1};

  assign p0_commit    = c0 | c1;
  assign p1_commit    = c0 & c1;
  assign p0_from_way1 = swap | (c1 & ~c0);
  assign p0_wen  = p0_from_way1 ? way1_wen_i     : way0_wen_i;
  assign p0_addr = p0_from_way1 ? way1_rd_addr_i : way0_rd_addr_i;
  assign p0_data = p0_from_way1 ? way1_rd_data_i : way0_rd_data_i;
  assign p1_wen  = swap ? way0_wen_i     : way1_wen_i;
  assign p1_addr = swap ? way0_rd_addr_i : way1_rd_addr_i;
  assign p1_data = swap ? way0_rd_data_i : way1_rd_data_i;

  // Same-cycle WAW: the younger write on port 1 wins
  assign waw = p1_commit & p0_wen & p1_wen & (p0_addr == p1_addr) & (p0_addr != '0);

  always_comb begin
    stall_nxt = stall_cnt;
    if (flush_i || (n_commit != 2'd0)) begin
      stall_nxt = '0;
    end else if (commit_en_i && (way0_valid_i || way1_valid_i) && (stall_cnt != CNT_MAX)) begin
      stall_nxt = stall_cnt + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_wen0_o      <= 1'b0;
      rf_waddr0_o    <= '0;
      rf_wdata0_o    <= '0;
      rf_wen1_o      <= 1'b0;
      rf_waddr1_o    <= '0;
      rf_wdata1_o    <= '0;
      retired_o      <= 2'd0;
      exp_pid        <= '0;
      stall_cnt      <= '0;
      pid_conflict_o <= 1'b0;
      deadlock_o     <= 1'b0;
    end else begin
      rf_wen0_o <= p0_commit & p0_wen & (p0_addr != '0) & ~waw;
      rf_wen1_o <= p1_commit & p1_wen & (p1_addr != '0);
      if (p0_commit) begin
        rf_waddr0_o <= p0_addr;
        rf_wdata0_o <= p0_data;
      end
      if (p1_commit) begin
        rf_waddr1_o <= p1_addr;
        rf_wdata1_o <= p1_data;
      end
      retired_o      <= n_commit;
      exp_pid        <= flush_i ? flush_pid_i : exp_pid + PID_WIDTH'(n_commit);
      stall_cnt      <= stall_nxt;
      pid_conflict_o <= pid_conflict_o | conflict;
      deadlock_o     <= deadlock_o | (stall_nxt == CNT_MAX);
    end
  end

  assign exp_pid_o = exp_pid;

endmodule

// File: tb/tb_wbu_commit_arbiter.sv
// Directed bench for wbu_commit_arbiter: ordered dual/single commits, WAW, flush,
// deadlock, pID conflict, x0 writes, commit hold and asynchronous reset.
module tb_wbu_commit_arbiter;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        way0_valid_i, way0_wen_i, way1_valid_i, way1_wen_i;
  logic [4:0]  way0_rd_addr_i, way1_rd_addr_i;
  logic [63:0] way0_rd_data_i, way1_rd_data_i;
  logic [1:0]  way0_pid_i, way1_pid_i;
  logic        way0_ready_o, way1_ready_o;
  logic        commit_en_i, flush_i;
  logic [1:0]  flush_pid_i;
  logic        rf_wen0_o, rf_wen1_o;
  logic [4:0]  rf_waddr0_o, rf_waddr1_o;
  logic [63:0] rf_wdata0_o, rf_wdata1_o;
  logic [1:0]  retired_o, exp_pid_o;
  logic        pid_conflict_o, deadlock_o;

  int checks = 0;
  int failures = 0;

  wbu_commit_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .way0_valid_i(way0_valid_i), .way0_wen_i(way0_wen_i), .way0_rd_addr_i(way0_rd_addr_i),
    .way0_rd_data_i(way0_rd_data_i), .way0_pid_i(way0_pid_i), .way0_ready_o(way0_ready_o),
    .way1_valid_i(way1_valid_i), .way1_wen_i(way1_wen_i), .way1_rd_addr_i(way1_rd_addr_i),
    .way1_rd_data_i(way1_rd_data_i), .way1_pid_i(way1_pid_i), .way1_ready_o(way1_ready_o),
    .commit_en_i(commit_en_i), .flush_i(flush_i), .flush_pid_i(flush_pid_i),
    .rf_wen0_o(rf_wen0_o), .rf_waddr0_o(rf_waddr0_o), .rf_wdata0_o(rf_wdata0_o),
    .rf_wen1_o(rf_wen1_o), .rf_waddr1_o(rf_waddr1_o), .rf_wdata1_o(rf_wdata1_o),
    .retired_o(retired_o), .exp_pid_o(exp_pid_o),
    .pid_conflict_o(pid_conflict_o), .deadlock_o(deadlock_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_way0(input logic v, input logic w, input logic [4:0] a,
                          input logic [63:0] d, input logic [1:0] p);
    way0_valid_i = v; way0_wen_i = w; way0_rd_addr_i = a; way0_rd_data_i = d; way0_pid_i = p;
  endtask

  task automatic set_way1(input logic v, input logic w, input logic [4:0] a,
                          input logic [63:0] d, input logic [1:0] p);
    way1_valid_i = v; way1_wen_i = w; way1_rd_addr_i = a; way1_rd_data_i = d; way1_pid_i = p;
  endtask

  task automatic idle();
    set_way0(1'b0, 1'b0, 5'd0, 64'd0, 2'd0);
    set_way1(1'b0, 1'b0, 5'd0, 64'd0, 2'd0);
    flush_i = 1'b0;
  endtask

  task automatic do_flush(input logic [1:0] p);
    idle();
    flush_i = 1'b1; flush_pid_i = p;
    step();
    flush_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; commit_en_i = 1'b1; flush_pid_i = 2'd0;
    idle();
    #12;
    checks++;
    if ({rf_wen0_o, rf_waddr0_o, rf_wdata0_o, rf_wen1_o, rf_waddr1_o, rf_wdata1_o} !== '0) begin
      $display("FAIL reset_ports got=%0h/%0h/%0h %0h/%0h/%0h exp=all 0", rf_wen0_o, rf_waddr0_o,
               rf_wdata0_o, rf_wen1_o, rf_waddr1_o, rf_wdata1_o);
      failures++;
    end
    checks++;
    if ({retired_o, exp_pid_o, pid_conflict_o, deadlock_o} !== 6'd0) begin
      $display("FAIL reset_status got=%b exp=000000", {retired_o, exp_pid_o, pid_conflict_o, deadlock_o});
      failures++;
    end
    @(negedge clk);
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_dual();
    set_way0(1'b1, 1'b1, 5'd5, 64'hA, 2'd0);
    set_way1(1'b1, 1'b1, 5'd6, 64'hB, 2'd1);
    #1;
    checks++;
    if ({way0_ready_o, way1_ready_o} !== 2'b11) begin
      $display("FAIL dual_ready got=%b exp=11", {way0_ready_o, way1_ready_o}); failures++;
    end
    step();
    idle();
    checks++;
    if ({rf_wen0_o, rf_waddr0_o, rf_wdata0_o} !== {1'b1, 5'd5, 64'hA}) begin
      $display("FAIL dual_port0 got=%0h/%0h/%0h exp=1/5/a", rf_wen0_o, rf_waddr0_o, rf_wdata0_o); failures++;
    end
    checks++;
    if ({rf_wen1_o, rf_waddr1_o, rf_wdata1_o} !== {1'b1, 5'd6, 64'hB}) begin
      $display("FAIL dual_port1 got=%0h/%0h/%0h exp=1/6/b", rf_wen1_o, rf_waddr1_o, rf_wdata1_o); failures++;
    end
    checks++;
    if ({retired_o, exp_pid_o} !== {2'd2, 2'd2}) begin
      $display("FAIL dual_retire got=%0d/%0d exp=2/2", retired_o, exp_pid_o); failures++;
    end
  endtask

  task automatic test_waw();
    set_way0(1'b1, 1'b1, 5'd1, 64'h11, 2'd2);
    step();
    idle();
    checks++;
    if ({rf_wen0_o, rf_waddr0_o, rf_wen1_o, retired_o, exp_pid_o} !== {1'b1, 5'd1, 1'b0, 2'd1, 2'd3}) begin
      $display("FAIL single_commit got=%0h/%0h/%0h/%0d/%0d exp=1/1/0/1/3", rf_wen0_o, rf_waddr0_o,
               rf_wen1_o, retired_o, exp_pid_o);
      failures++;
    end
    set_way1(1'b1, 1'b1, 5'd7, 64'h77, 2'd3);
    set_way0(1'b1, 1'b1, 5'd7, 64'h70, 2'd0);
    #1;
    checks++;
    if ({way0_ready_o, way1_ready_o} !== 2'b11) begin
      $display("FAIL waw_ready got=%b exp=11", {way0_ready_o, way1_ready_o}); failures++;
    end
    step();
    idle();
    checks++;
    if ({rf_wen0_o, rf_waddr0_o, rf_wdata0_o} !== {1'b0, 5'd7, 64'h77}) begin
      $display("FAIL waw_port0 got=%0h/%0h/%0h exp=0/7/77", rf_wen0_o, rf_waddr0_o, rf_wdata0_o); failures++;
    end
    checks++;
    if ({rf_wen1_o, rf_waddr1_o, rf_wdata1_o} !== {1'b1, 5'd7, 64'h70}) begin
      $display("FAIL waw_port1 got=%0h/%0h/%0h exp=1/7/70", rf_wen1_o, rf_waddr1_o, rf_wdata1_o); failures++;
    end
    checks++;
    if (exp_pid_o !== 2'd1) begin
      $display("FAIL waw_wrap got=%0d exp=1", exp_pid_o); failures++;
    end
  endtask

  task automatic test_commit_en();
    commit_en_i = 1'b0;
    set_way0(1'b1, 1'b1, 5'd10, 64'hAB, 2'd1);
    set_way1(1'b1, 1'b1, 5'd11, 64'hCD, 2'd2);
    for (int i = 0; i < 20; i++) begin
      #1;
      checks++;
      if ({way0_ready_o, way1_ready_o} !== 2'b00) begin
        $display("FAIL hold_ready cycle=%0d got=%b exp=00", i, {way0_ready_o, way1_ready_o}); failures++;
      end
      step();
    end
    checks++;
    if ({deadlock_o, exp_pid_o} !== {1'b0, 2'd1}) begin
      $display("FAIL hold_frozen got=%0h/%0d exp=0/1", deadlock_o, exp_pid_o); failures++;
    end
    commit_en_i = 1'b1;
    #1;
    checks++;
    if ({way0_ready_o, way1_ready_o} !== 2'b11) begin
      $display("FAIL release_ready got=%b exp=11", {way0_ready_o, way1_ready_o}); failures++;
    end
    step();
    idle();
    checks++;
    if ({rf_wen0_o, rf_waddr0_o, rf_wdata0_o, rf_wen1_o, rf_waddr1_o, rf_wdata1_o, retired_o, exp_pid_o}
        !== {1'b1, 5'd10, 64'hAB, 1'b1, 5'd11, 64'hCD, 2'd2, 2'd3}) begin
      $display("FAIL release_commit got=%0h/%0h/%0h %0h/%0h/%0h r=%0d e=%0d exp=1/a/ab 1/b/cd r=2 e=3",
               rf_wen0_o, rf_waddr0_o, rf_wdata0_o, rf_wen1_o, rf_waddr1_o, rf_wdata1_o, retired_o, exp_pid_o);
      failures++;
    end
  endtask

  task automatic test_deadlock();
    do_flush(2'd0);
    checks++;
    if ({exp_pid_o, rf_wen0_o, rf_wen1_o, retired_o} !== {2'd0, 1'b0, 1'b0, 2'd0}) begin
      $display("FAIL flush_idle got=%0d/%0h/%0h/%0d exp=0/0/0/0", exp_pid_o, rf_wen0_o, rf_wen1_o, retired_o);
      failures++;
    end
    set_way0(1'b1, 1'b1, 5'd9, 64'h99, 2'd2);
    for (int i = 0; i < 15; i++) begin
      #1;
      checks++;
      if (way0_ready_o !== 1'b0) begin
        $display("FAIL stall_ready cycle=%0d got=%0h exp=0", i, way0_ready_o); failures++;
      end
      step();
    end
    checks++;
    if (deadlock_o !== 1'b0) begin
      $display("FAIL deadlock_early got=%0h exp=0", deadlock_o); failures++;
    end
    step();
    checks++;
    if (deadlock_o !== 1'b1) begin
      $display("FAIL deadlock_set got=%0h exp=1", deadlock_o); failures++;
    end
    flush_i = 1'b1; flush_pid_i = 2'd2;
    #1;
    checks++;
    if (way0_ready_o !== 1'b0) begin
      $display("FAIL flush_block_ready got=%0h exp=0", way0_ready_o); failures++;
    end
    step();
    flush_i = 1'b0;
    checks++;
    if ({exp_pid_o, rf_wen0_o, deadlock_o} !== {2'd2, 1'b0, 1'b1}) begin
      $display("FAIL flush_resync got=%0d/%0h/%0h exp=2/0/1", exp_pid_o, rf_wen0_o, deadlock_o); failures++;
    end
    #1;
    checks++;
    if (way0_ready_o !== 1'b1) begin
      $display("FAIL resync_ready got=%0h exp=1", way0_ready_o); failures++;
    end
    step();
    idle();
    checks++;
    if ({rf_wen0_o, rf_waddr0_o, rf_wdata0_o, deadlock_o, exp_pid_o} !== {1'b1, 5'd9, 64'h99, 1'b1, 2'd3}) begin
      $display("FAIL resync_commit got=%0h/%0h/%0h/%0h/%0d exp=1/9/99/1/3", rf_wen0_o, rf_waddr0_o,
               rf_wdata0_o, deadlock_o, exp_pid_o);
      failures++;
    end
  endtask

  task automatic test_conflict();
    do_flush(2'd0);
    set_way0(1'b1, 1'b1, 5'd3, 64'h31, 2'd0);
    set_way1(1'b1, 1'b1, 5'd4, 64'h41, 2'd0);
    #1;
    checks++;
    if ({way0_ready_o, way1_ready_o, pid_conflict_o} !== 3'b100) begin
      $display("FAIL conflict_ready got=%b exp=100", {way0_ready_o, way1_ready_o, pid_conflict_o}); failures++;
    end
    step();
    set_way0(1'b0, 1'b0, 5'd0, 64'd0, 2'd0);
    set_way1(1'b1, 1'b1, 5'd4, 64'h41, 2'd1);
    checks++;
    if ({pid_conflict_o, rf_wen0_o, rf_waddr0_o, rf_wdata0_o, rf_wen1_o, retired_o, exp_pid_o}
        !== {1'b1, 1'b1, 5'd3, 64'h31, 1'b0, 2'd1, 2'd1}) begin
      $display("FAIL conflict_commit got=%0h %0h/%0h/%0h %0h r=%0d e=%0d exp=1 1/3/31 0 r=1 e=1",
               pid_conflict_o, rf_wen0_o, rf_waddr0_o, rf_wdata0_o, rf_wen1_o, retired_o, exp_pid_o);
      failures++;
    end
    #1;
    checks++;
    if ({way0_ready_o, way1_ready_o} !== 2'b01) begin
      $display("FAIL way1_follow_ready got=%b exp=01", {way0_ready_o, way1_ready_o}); failures++;
    end
    step();
    idle();
    checks++;
    if ({rf_wen0_o, rf_waddr0_o, rf_wdata0_o, exp_pid_o} !== {1'b1, 5'd4, 64'h41, 2'd2}) begin
      $display("FAIL way1_on_port0 got=%0h/%0h/%0h/%0d exp=1/4/41/2", rf_wen0_o, rf_waddr0_o,
               rf_wdata0_o, exp_pid_o);
      failures++;
    end
    checks++;
    if ({rf_wen1_o, rf_waddr1_o, rf_wdata1_o} !== {1'b0, 5'd11, 64'hCD}) begin
      $display("FAIL port1_hold got=%0h/%0h/%0h exp=0/b/cd", rf_wen1_o, rf_waddr1_o, rf_wdata1_o); failures++;
    end
  endtask

  task automatic test_zero_rd_and_flush();
    set_way0(1'b1, 1'b1, 5'd0, 64'h5, 2'd2);
    #1;
    checks++;
    if (way0_ready_o !== 1'b1) begin
      $display("FAIL x0_ready got=%0h exp=1", way0_ready_o); failures++;
    end
    step();
    checks++;
    if ({rf_wen0_o, retired_o, exp_pid_o} !== {1'b0, 2'd1, 2'd3}) begin
      $display("FAIL x0_commit got=%0h/%0d/%0d exp=0/1/3", rf_wen0_o, retired_o, exp_pid_o); failures++;
    end
    set_way0(1'b1, 1'b1, 5'd1, 64'h61, 2'd3);
    set_way1(1'b1, 1'b1, 5'd2, 64'h62, 2'd0);
    flush_i = 1'b1; flush_pid_i = 2'd1;
    #1;
    checks++;
    if ({way0_ready_o, way1_ready_o} !== 2'b00) begin
      $display("FAIL flush_prio_ready got=%b exp=00", {way0_ready_o, way1_ready_o}); failures++;
    end
    step();
    idle();
    checks++;
    if ({rf_wen0_o, rf_wen1_o, retired_o, exp_pid_o} !== {1'b0, 1'b0, 2'd0, 2'd1}) begin
      $display("FAIL flush_prio got=%0h/%0h/%0d/%0d exp=0/0/0/1", rf_wen0_o, rf_wen1_o, retired_o, exp_pid_o);
      failures++;
    end
  endtask

  task automatic test_reset_mid();
    set_way0(1'b1, 1'b1, 5'd12, 64'h12, 2'd1);
    step();
    idle();
    checks++;
    if ({rf_wen0_o, rf_waddr0_o} !== {1'b1, 5'd12}) begin
      $display("FAIL pre_reset_write got=%0h/%0h exp=1/c", rf_wen0_o, rf_waddr0_o); failures++;
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({rf_wen0_o, rf_waddr0_o, rf_wdata0_o, retired_o, exp_pid_o, pid_conflict_o, deadlock_o} !== '0) begin
      $display("FAIL async_reset got=%0h/%0h/%0h r=%0d e=%0d c=%0h d=%0h exp=all 0", rf_wen0_o,
               rf_waddr0_o, rf_wdata0_o, retired_o, exp_pid_o, pid_conflict_o, deadlock_o);
      failures++;
    end
  endtask

  initial begin
    test_reset();
    test_dual();
    test_waw();
    test_commit_en();
    test_deadlock();
    test_conflict();
    test_zero_rd_and_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wbu_commit_arbiter.md
Name: wbu_commit_arbiter

Overview:
- Writeback commit arbiter for the dual-issue core. It sits between the way0/way1 WBU register buffers and the two integer register-file write ports.
- Each cycle it pops buffered writeback entries in program order, using each entry's pID tag, and drives up to two register-file writes.
- It resolves same-cycle WAW collisions, handles flush re-synchronisation of the expected pID, and flags ordering faults and deadlock.

Parameters:
DATA_WIDTH, 64, writeback data width
ADDR_WIDTH, 5, register address width
PID_WIDTH, 2, program-order tag width; tags wrap modulo 2**PID_WIDTH
STALL_LIMIT, 16, consecutive no-progress cycles before deadlock_o asserts

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
way0_valid_i  in  1  way0 buffer holds an entry
way0_wen_i  in  1  way0 entry writes rd
way0_rd_addr_i  in  ADDR_WIDTH  way0 rd address
way0_rd_data_i  in  DATA_WIDTH  way0 rd data
way0_pid_i  in  PID_WIDTH  way0 program-order tag
way0_ready_o  out  1  pop way0 entry this cycle (combinational)
way1_valid_i, way1_wen_i, way1_rd_addr_i, way1_rd_data_i, way1_pid_i, way1_ready_o  same as way0, for way1
commit_en_i  in  1  0 = hold all commits (debug halt / downstream stall)
flush_i  in  1  pipeline flush
flush_pid_i  in  PID_WIDTH  expected pID after flush
rf_wen0_o  out  1  write port 0 enable (older instruction)
rf_waddr0_o  out  ADDR_WIDTH  port 0 address
rf_wdata0_o  out  DATA_WIDTH  port 0 data
rf_wen1_o, rf_waddr1_o, rf_wdata1_o  out  1/ADDR_WIDTH/DATA_WIDTH  port 1 (younger instruction)
retired_o  out  2  entries committed last cycle (0..2)
exp_pid_o  out  PID_WIDTH  current expected pID
pid_conflict_o  out  1  sticky: both ways presented the same pID
deadlock_o  out  1  sticky: stall counter reached STALL_LIMIT

Behaviour:
- Reset (async): all rf_* outputs 0, retired_o 0, exp_pid 0, stall counter 0, both sticky flags 0.
- Match rules:
  - m0 = way0_valid_i & (way0_pid_i == exp_pid); m1 is the same for way1.
  - n0/n1 = way0/way1 valid & pid == exp_pid+1 (mod wrap).
- Commit selection, evaluated only when commit_en_i=1 and flush_i=0:
  - m0 & n1: commit way0 (older, port 0) and way1 (port 1).
  - m1 & n0: commit way1 (port 0) and way0 (port 1).
  - m0 & m1: set pid_conflict_o; commit way0 only.
  - Only m0 or only m1: single commit on port 0.
  - Otherwise: no commit.
- wayX_ready_o is high in exactly the cycles wayX is committed. It is combinational from the inputs and state.
- exp_pid advances by the number of commits, mod 2**PID_WIDTH.
- Write ports are registered, with 1-cycle latency from pop to rf_wen.
  - A port's wen = committed & entry wen & rd_addr != 0.
  - Ports carrying no commit have wen=0, and their addr/data hold their previous values.
  - retired_o = number of commits, registered.
- WAW: if both commits write the same nonzero rd, port 0 wen is forced to 0 and the younger entry (port 1) wins.
- Flush:
  - Flush takes priority over any commit in the same cycle: no pops, and the next-cycle rf_wen* are 0.
  - exp_pid <= flush_pid_i and the stall counter clears.
  - Sticky flags are not cleared by flush.
- Stall counter:
  - Increments when commit_en_i=1, flush_i=0, (way0_valid_i | way1_valid_i), and no commit. It saturates at STALL_LIMIT.
  - It clears on any commit.
  - deadlock_o sets when the counter reaches STALL_LIMIT.
  - commit_en_i=0 holds the counter.
- Reset asserted mid-operation: any pending registered write is discarded; outputs go to reset values immediately.
- pID wrap: with exp_pid=3, a dual commit of pIDs 3 and 0 gives exp_pid 1.

Test Plan:
- After reset, way0 {pid0, x5, 0xA} and way1 {pid1, x6, 0xB} both valid -> both readys high in the same cycle; next cycle wen0=1 addr0=5 data0=0xA, wen1=1 addr1=6 data1=0xB, retired_o=2, exp_pid_o=2.
- exp_pid=3, way1 pid3 x7, way0 pid0 x7 -> way1 on port 0 with wen0=0 (WAW); port 1 writes x7 with way0's data; exp_pid_o=1.
- Way0 pid2 only, exp_pid=0, commit_en_i=1 for 16 cycles -> no ready; deadlock_o=1 at cycle 16. Then flush_i with flush_pid_i=2 -> next cycle way0 commits; deadlock_o stays 1.
- Both ways pid0 at exp_pid=0 -> pid_conflict_o=1; only way0 pops; way1 pops the following cycle.
- Entry rd_addr=0 with wen=1 -> popped, rf_wen0_o=0, retired_o=1. Same-cycle flush_i with matching entries -> no ready, rf_wen*=0, exp_pid_o=flush_pid_i.
- commit_en_i=0 with matching entries -> no pops and stall counter frozen; raising commit_en_i commits on the next cycle.
